// File: rtl/board_click_tracker_pkg.sv
// Shared constants and types for the board cursor / click tracker.
package board_click_tracker_pkg;

    // Defaults for the board geometry, used as parameter defaults.
    localparam int unsigned COORD_W_DEF     = 12;
    localparam int unsigned BOARD_X0_DEF    = 256;
    localparam int unsigned BOARD_Y0_DEF    = 128;
    localparam int unsigned SQUARE_LOG2_DEF = 6;
    localparam int unsigned BOARD_N_DEF     = 8;
    localparam int unsigned MIN_PRESS_DEF   = 4;

    localparam int unsigned IDX_W_DEF = $clog2(BOARD_N_DEF);

    // Square index packed as {col,row} for the default board size.
    typedef logic [2*IDX_W_DEF-1:0] board_pos_t;

endpackage

// File: rtl/board_click_tracker_if.sv
// Mouse-side inputs and game-logic-side outputs of the click tracker.
interface board_click_tracker_if
    import board_click_tracker_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF
);
    logic                 lmb;
    logic                 rmb;
    logic [COORD_W-1:0]   mouse_xpos;
    logic [COORD_W-1:0]   mouse_ypos;
    logic [2*IDX_W-1:0]   hover_pos;
    logic                 hover_valid;
    logic                 holding;
    logic [2*IDX_W-1:0]   src_pos;
    logic [2*IDX_W-1:0]   dst_pos;
    logic                 pick_pulse;
    logic                 place_pulse;
    logic                 cancel_pulse;

    modport master (
        output lmb, rmb, mouse_xpos, mouse_ypos,
        input  hover_pos, hover_valid, holding, src_pos, dst_pos,
        input  pick_pulse, place_pulse, cancel_pulse
    );

    modport slave (
        input  lmb, rmb, mouse_xpos, mouse_ypos,
        output hover_pos, hover_valid, holding, src_pos, dst_pos,
        output pick_pulse, place_pulse, cancel_pulse
    );
endinterface

// File: rtl/button_click_filter.sv
// Turns a button level into a single-cycle click on release of a long-enough press.
module button_click_filter #(
    parameter int unsigned MIN_PRESS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic click
);
    localparam logic [7:0] MinPress = 8'(MIN_PRESS);

    logic [7:0] cnt_q;
    logic       btn_q;

    // Count held cycles (saturating) and remember the previous level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
            if (btn) begin
                if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= 8'd0;
            end
        end
    end

    // Only the release cycle can fire, so a held button never repeats.
    assign click = btn_q && !btn && (cnt_q >= MinPress);

endmodule

// File: rtl/board_click_tracker.sv
// Decodes the cursor onto the board grid and runs the pick/place state machine.
module board_click_tracker
    import board_click_tracker_pkg::*;
#(
    parameter int unsigned COORD_W     = COORD_W_DEF,
    parameter int unsigned BOARD_X0    = BOARD_X0_DEF,
    parameter int unsigned BOARD_Y0    = BOARD_Y0_DEF,
    parameter int unsigned SQUARE_LOG2 = SQUARE_LOG2_DEF,
    parameter int unsigned BOARD_N     = BOARD_N_DEF,
    parameter int unsigned MIN_PRESS   = MIN_PRESS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    board_click_tracker_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(BOARD_N);
    localparam int unsigned POS_W = 2 * IDX_W;
    localparam logic [COORD_W:0] Span = (COORD_W+1)'(BOARD_N << SQUARE_LOG2);
    localparam logic [COORD_W:0] X0   = (COORD_W+1)'(BOARD_X0);
    localparam logic [COORD_W:0] Y0   = (COORD_W+1)'(BOARD_Y0);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t             state_q;
    logic [POS_W-1:0]   hover_pos_q, src_pos_q, dst_pos_q;
    logic               hover_valid_q, holding_q;
    logic               pick_q, place_q, cancel_q;
    logic               lmb_click, rmb_click;

    // One extra bit keeps left/above-board coordinates negative instead of wrapping.
    logic [COORD_W:0]   dx, dy;
    logic               in_x, in_y;
    logic [IDX_W-1:0]   col, row;

    assign dx   = {1'b0, bus.mouse_xpos} - X0;
    assign dy   = {1'b0, bus.mouse_ypos} - Y0;
    assign in_x = !dx[COORD_W] && (dx < Span);
    assign in_y = !dy[COORD_W] && (dy < Span);
    assign col  = dx[SQUARE_LOG2 +: IDX_W];
    assign row  = dy[SQUARE_LOG2 +: IDX_W];

    button_click_filter #(.MIN_PRESS(MIN_PRESS)) u_lmb_filter (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.lmb),
        .click (lmb_click)
    );

    button_click_filter #(.MIN_PRESS(MIN_PRESS)) u_rmb_filter (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.rmb),
        .click (rmb_click)
    );

    // Register the hovered square; the last valid square is kept while off-board.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hover_pos_q   <= '0;
            hover_valid_q <= 1'b0;
        end else begin
            hover_valid_q <= in_x && in_y;
            if (in_x && in_y) hover_pos_q <= {col, row};
        end
    end

    // Pick/place FSM; rmb wins over a simultaneous lmb click.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            holding_q <= 1'b0;
            src_pos_q <= '0;
            dst_pos_q <= '0;
            pick_q    <= 1'b0;
            place_q   <= 1'b0;
            cancel_q  <= 1'b0;
        end else begin
            pick_q   <= 1'b0;
            place_q  <= 1'b0;
            cancel_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (lmb_click && !rmb_click && hover_valid_q) begin
                        src_pos_q <= hover_pos_q;
                        pick_q    <= 1'b1;
                        holding_q <= 1'b1;
                        state_q   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (rmb_click) begin
                        cancel_q  <= 1'b1;
                        holding_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (lmb_click && hover_valid_q) begin
                        // Dropping back on the source square is a cancel, not a move.
                        if (hover_pos_q != src_pos_q) begin
                            dst_pos_q <= hover_pos_q;
                            place_q   <= 1'b1;
                        end else begin
                            cancel_q  <= 1'b1;
                        end
                        holding_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.hover_pos    = hover_pos_q;
    assign bus.hover_valid  = hover_valid_q;
    assign bus.holding      = holding_q;
    assign bus.src_pos      = src_pos_q;
    assign bus.dst_pos      = dst_pos_q;
    assign bus.pick_pulse   = pick_q;
    assign bus.place_pulse  = place_q;
    assign bus.cancel_pulse = cancel_q;

endmodule

// File: tb/tb_board_click_tracker.sv
// Self-checking bench: strobe events are scored against a queue of expected events.
module tb_board_click_tracker;
    import board_click_tracker_pkg::*;

    localparam int MIN_PRESS = 4;

    typedef struct packed {
        logic [2:0] kind;   // {pick,place,cancel}
        logic [5:0] src;
        logic [5:0] dst;
        logic       hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    // Reference model state.
    logic       m_hold = 1'b0;
    logic [5:0] m_src  = '0;
    logic [5:0] m_dst  = '0;
    logic [5:0] m_hp   = '0;
    logic       m_hv   = 1'b0;

    board_click_tracker_if bus ();

    board_click_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Independent model of the grid decode.
    function automatic void decode(input int x, input int y, output logic v,
                                   output logic [5:0] p);
        int dx, dy;
        dx = x - 256;
        dy = y - 128;
        v  = (dx >= 0) && (dx < 512) && (dy >= 0) && (dy < 512);
        p  = {3'(dx / 64), 3'(dy / 64)};
    endfunction

    // Score every strobe against the oldest expected event.
    always @(negedge clk) begin : monitor
        logic [2:0] kind;
        exp_t       e;
        kind = {bus.pick_pulse, bus.place_pulse, bus.cancel_pulse};
        if (!rst && kind != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(kind), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(kind), 32'(e.kind));
                check("strobe_src", 32'(bus.src_pos), 32'(e.src));
                check("strobe_dst", 32'(bus.dst_pos), 32'(e.dst));
                check("strobe_holding", 32'(bus.holding), 32'(e.hold));
            end
        end
    end

    task automatic set_pos(input int x, input int y, input string tag);
        logic       v;
        logic [5:0] p;
        @(posedge clk);
        #1;
        bus.mouse_xpos = 12'(x);
        bus.mouse_ypos = 12'(y);
        decode(x, y, v, p);
        m_hv = v;
        if (v) m_hp = p;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.hover_valid), 32'(m_hv));
        check({tag, "_pos"}, 32'(bus.hover_pos), 32'(m_hp));
    endtask

    // Hold the selected buttons for n cycles, release, and predict the outcome.
    task automatic click_btn(input logic l, input logic r, input int n, input string tag);
        exp_t e;
        logic lc, rc;
        lc = l && (n >= MIN_PRESS);
        rc = r && (n >= MIN_PRESS);
        e.kind = 3'b000;
        if (rc) begin
            if (m_hold) begin
                e.kind = 3'b001;
                m_hold = 1'b0;
            end
        end else if (lc && m_hv) begin
            if (!m_hold) begin
                e.kind = 3'b100;
                m_src  = m_hp;
                m_hold = 1'b1;
            end else if (m_hp != m_src) begin
                e.kind = 3'b010;
                m_dst  = m_hp;
                m_hold = 1'b0;
            end else begin
                e.kind = 3'b001;
                m_hold = 1'b0;
            end
        end
        e.src  = m_src;
        e.dst  = m_dst;
        e.hold = m_hold;
        if (e.kind != 3'b000) exp_q.push_back(e);

        @(posedge clk);
        #1;
        bus.lmb = l;
        bus.rmb = r;
        repeat (n) @(posedge clk);
        #1;
        bus.lmb = 1'b0;
        bus.rmb = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_holding"}, 32'(bus.holding), 32'(m_hold));
        check({tag, "_src"}, 32'(bus.src_pos), 32'(m_src));
        check({tag, "_dst"}, 32'(bus.dst_pos), 32'(m_dst));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hover_pos"}, 32'(bus.hover_pos), 32'd0);
        check({tag, "_hover_valid"}, 32'(bus.hover_valid), 32'd0);
        check({tag, "_holding"}, 32'(bus.holding), 32'd0);
        check({tag, "_src"}, 32'(bus.src_pos), 32'd0);
        check({tag, "_dst"}, 32'(bus.dst_pos), 32'd0);
        check({tag, "_strobes"},
              32'({bus.pick_pulse, bus.place_pulse, bus.cancel_pulse}), 32'd0);
    endtask

    initial begin
        bus.lmb        = 1'b0;
        bus.rmb        = 1'b0;
        bus.mouse_xpos = 12'd0;
        bus.mouse_ypos = 12'd0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Decode and boundaries.
        set_pos(400, 300, "dec_2_2");
        set_pos(255, 300, "dec_left");
        set_pos(256, 128, "dec_0_0");
        set_pos(767, 639, "dec_7_7");
        set_pos(768, 639, "dec_right");
        set_pos(10, 10, "dec_under1");
        set_pos(0, 0, "dec_under0");

        // Debounce and press length.
        set_pos(400, 300, "dbn_pos");
        click_btn(1'b1, 1'b0, 3, "short_press");
        click_btn(1'b1, 1'b0, 4, "min_press_pick");
        click_btn(1'b0, 1'b1, 4, "rmb_cancel");
        click_btn(1'b1, 1'b0, 1000, "long_press_pick");
        click_btn(1'b1, 1'b0, 5, "same_sq_cancel");
        click_btn(1'b0, 1'b1, 6, "rmb_idle");

        // Full move.
        set_pos(300, 150, "mv_src");
        click_btn(1'b1, 1'b0, 4, "mv_pick");
        set_pos(430, 400, "mv_dst");
        click_btn(1'b1, 1'b0, 4, "mv_place");

        // Simultaneous release while holding: cancel only.
        click_btn(1'b1, 1'b0, 4, "both_pick");
        click_btn(1'b1, 1'b1, 5, "both_cancel");

        // Off-board lmb while holding is ignored.
        click_btn(1'b1, 1'b0, 4, "off_pick");
        set_pos(0, 0, "off_pos");
        click_btn(1'b1, 1'b0, 4, "off_ignored");

        // Asynchronous reset mid-cycle while holding.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        m_hold = 1'b0;
        m_src  = '0;
        m_dst  = '0;
        m_hp   = '0;
        m_hv   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_pos(430, 400, "post_rst_pos");
        click_btn(1'b1, 1'b0, 4, "post_rst_pick");

        repeat (2) @(posedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_click_tracker.md
Name: board_click_tracker

Overview:
- Parametrised successor to the board cursor decoder. Maps mouse pixel coordinates onto an N x N board grid with explicit on/off-board detection.
- Filters LMB/RMB into clean click events.
- Runs a pick/place state machine that latches source and destination squares.
- Sits between the mouse controller and the game-logic/move-validation blocks; all outputs are registered.

Parameters:
- COORD_W, 12, width of mouse_xpos/mouse_ypos.
- BOARD_X0, 256, pixel x of the board's left edge.
- BOARD_Y0, 128, pixel y of the board's top edge.
- SQUARE_LOG2, 6, log2 of square size in pixels (default 64 px).
- BOARD_N, 8, squares per side; power of two, 2..16.
- MIN_PRESS, 4, minimum held cycles for a press to count as a click (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- lmb  in  1  left mouse button level, synchronous to clk
- rmb  in  1  right mouse button level, synchronous to clk
- mouse_xpos  in  COORD_W  cursor x in pixels
- mouse_ypos  in  COORD_W  cursor y in pixels
- hover_pos  out  2*IDX_W  square under cursor, {col,row}; IDX_W = $clog2(BOARD_N)
- hover_valid  out  1  cursor is inside the board
- holding  out  1  a piece is picked and awaiting placement
- src_pos  out  2*IDX_W  square latched at pick
- dst_pos  out  2*IDX_W  square latched at place
- pick_pulse  out  1  one-cycle strobe on pick
- place_pulse  out  1  one-cycle strobe on place
- cancel_pulse  out  1  one-cycle strobe on cancel

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - all outputs 0, FSM in S_IDLE, press counters 0.
  - A reset mid-operation discards any held piece; no strobe is emitted.
- Position decode, 1-cycle latency:
  - dx = x - BOARD_X0 and dy = y - BOARD_Y0, each computed at COORD_W+1 bits signed.
  - Inside when 0 <= dx < BOARD_N<<SQUARE_LOG2, and likewise for dy.
  - Coordinates left of or above the board must never wrap into a valid index.
  - When inside: col = dx>>SQUARE_LOG2, row = dy>>SQUARE_LOG2, hover_pos = {col,row}, hover_valid = 1.
  - When outside: hover_valid = 0 and hover_pos holds its last valid value.
- Click filter (per button):
  - 8-bit counter increments while the button is high, saturating at 255.
  - On a falling edge (previous high, current low):
    - counter >= MIN_PRESS: emit an internal click for exactly one cycle.
    - otherwise: no click.
  - Counter clears on low.
  - A held button never repeats.
- FSM, 2 states; each click is evaluated against hover_pos/hover_valid registered in the same cycle:
  - S_IDLE:
    - lmb click with hover_valid: src_pos <= hover_pos, pick_pulse = 1 next cycle, go to S_HOLD, holding = 1.
    - lmb click off-board: ignored.
    - rmb click: ignored.
  - S_HOLD:
    - rmb click: cancel_pulse, go to S_IDLE.
    - lmb click on-board with hover_pos != src_pos: dst_pos <= hover_pos, place_pulse, go to S_IDLE.
    - lmb click on-board with hover_pos == src_pos: cancel_pulse, go to S_IDLE; dst_pos unchanged.
    - lmb click off-board: ignored; stays in S_HOLD.
  - lmb click and rmb click in the same cycle: rmb has priority (cancel in S_HOLD, nothing in S_IDLE).
- Strobes:
  - pick_pulse, place_pulse and cancel_pulse are mutually exclusive and registered.
  - Each is high exactly one cycle, asserted the cycle after the click is detected.
- holding:
  - Rises together with pick_pulse.
  - Falls together with place_pulse or cancel_pulse.
- src_pos/dst_pos are stable outside these updates.

Decomposition:
- vga_pkg gains BOARD_X0, BOARD_Y0, SQUARE_LOG2 and BOARD_N as shared constants (used as parameter defaults) and a typedef board_pos_t.
- board_click_tracker gains the FSM state enum {S_IDLE, S_HOLD}.
- Sub-module button_click_filter (params MIN_PRESS; ports clk, rst, btn, click) is instantiated twice, once for lmb and once for rmb.

Test Plan:
- Decode: (400,300) -> next cycle hover_pos = {3'd2,3'd2}, hover_valid = 1. Then (255,300) -> hover_valid = 0, hover_pos stays {2,2}. Then (256,128) -> {0,0}. Then (767,639) -> {7,7}. Then (768,639) -> invalid.
- Underflow: (10,10) and (0,0) -> hover_valid = 0; hover_pos never updates.
- Debounce with MIN_PRESS = 4:
  - lmb high 3 cycles -> no pick_pulse.
  - lmb high 4 cycles, then low -> pick_pulse 1 cycle, src_pos = hover.
  - lmb high 1000 cycles -> exactly one pick.
- Full move: click at (300,150) [{0,0}], then click at (430,400) [{2,4}] -> pick_pulse, holding = 1; then place_pulse with dst_pos = {2,4}, holding = 0.
- Cancel paths:
  - rmb click in S_HOLD -> cancel_pulse, src_pos kept.
  - Second lmb on the same square -> cancel_pulse, no place_pulse.
  - lmb+rmb clicks released in the same cycle in S_HOLD -> cancel only.
  - Off-board lmb in S_HOLD -> no strobe, holding stays 1.
- Reset: assert rst asynchronously mid-cycle in S_HOLD -> holding, strobes, src_pos, dst_pos and hover outputs all 0 immediately; after release, a single click produces a pick, not a place.
